// File: rtl/maze_pkg.sv
// Shared definitions for the maze player datapath.
// Holds the default grid geometry, the coordinate and address widths, the
// player FSM state encoding, the direction codes and the key-priority helper.
package maze_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;
  localparam int X_W    = 5;
  localparam int Y_W    = 4;
  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    ERASE = 3'd4,
    DRAW  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  // Resolve simultaneous key presses: up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_t d;
    d = DIR_NONE;
    if (up)         d = DIR_UP;
    else if (down)  d = DIR_DOWN;
    else if (left)  d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/move_target_calc.sv
// Combinational move target generator.
// Picks one direction from the key inputs, rejects moves that would leave the
// grid, and produces the target cell plus its wall-memory address.
// Ports:
//   cur_x, cur_y     current player position
//   key_*            synchronised direction keys, active high
//   move_ok          1 = a key is pressed and the target lies on the grid
//   tgt_x, tgt_y     target cell (equals current cell when move_ok=0)
//   tgt_addr         tgt_y*GRID_W + tgt_x
module move_target_calc
  import maze_pkg::*;
#(
  parameter int GRID_W = maze_pkg::GRID_W,
  parameter int GRID_H = maze_pkg::GRID_H
) (
  input  logic [X_W-1:0]    cur_x,
  input  logic [Y_W-1:0]    cur_y,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  output logic              move_ok,
  output logic [X_W-1:0]    tgt_x,
  output logic [Y_W-1:0]    tgt_y,
  output logic [ADDR_W-1:0] tgt_addr
);

  dir_t dir;

  assign dir = pick_dir(key_up, key_down, key_left, key_right);

  // Bounds are tested on the current cell before the +/-1, so the
  // arithmetic below can never wrap.
  always_comb begin
    move_ok = 1'b0;
    tgt_x   = cur_x;
    tgt_y   = cur_y;
    case (dir)
      DIR_UP: begin
        if (cur_y != '0) begin
          move_ok = 1'b1;
          tgt_y   = cur_y - 1'b1;
        end
      end
      DIR_DOWN: begin
        if (cur_y != Y_W'(GRID_H - 1)) begin
          move_ok = 1'b1;
          tgt_y   = cur_y + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (cur_x != '0) begin
          move_ok = 1'b1;
          tgt_x   = cur_x - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (cur_x != X_W'(GRID_W - 1)) begin
          move_ok = 1'b1;
          tgt_x   = cur_x + 1'b1;
        end
      end
      default: begin
        move_ok = 1'b0;
      end
    endcase
  end

  assign tgt_addr = ADDR_W'(tgt_y) * ADDR_W'(GRID_W) + ADDR_W'(tgt_x);

endmodule

// File: rtl/player_move_fsm.sv
// Player movement controller for the maze game.
// On every 8 Hz tick (rate_count == 0) while idle, samples the direction keys,
// looks the target cell up in the wall memory and, if it is open, moves the
// player by asking the plotter to erase the old cell and draw the new one.
// Ports:
//   clock, resetn                 system clock, synchronous active-low reset
//   rate_count                    rate-divider count, tick when zero
//   key_up/down/left/right        synchronised direction keys
//   wall_addr, wall_data          wall-memory read port (MEM_LAT latency)
//   draw_req/x/y/erase, draw_ack  plot request handshake
//   player_x, player_y            current player cell
//   at_goal                       sticky goal-reached flag
//   busy                          high whenever the FSM is not idle
module player_move_fsm
  import maze_pkg::*;
#(
  parameter int GRID_W  = maze_pkg::GRID_W,
  parameter int GRID_H  = maze_pkg::GRID_H,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 19,
  parameter int GOAL_Y  = 14,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [22:0]       rate_count,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  output logic [ADDR_W-1:0] wall_addr,
  input  logic              wall_data,
  output logic              draw_req,
  output logic [X_W-1:0]    draw_x,
  output logic [Y_W-1:0]    draw_y,
  output logic              draw_erase,
  input  logic              draw_ack,
  output logic [X_W-1:0]    player_x,
  output logic [Y_W-1:0]    player_y,
  output logic              at_goal,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [X_W-1:0]     tgt_x;
  logic [Y_W-1:0]     tgt_y;
  logic               tick;
  logic               calc_ok;
  logic [X_W-1:0]     calc_x;
  logic [Y_W-1:0]     calc_y;
  logic [ADDR_W-1:0]  calc_addr;

  assign tick = (rate_count == '0);
  assign busy = (state != IDLE);

  move_target_calc #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_calc (
    .cur_x     (player_x),
    .cur_y     (player_y),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .move_ok   (calc_ok),
    .tgt_x     (calc_x),
    .tgt_y     (calc_y),
    .tgt_addr  (calc_addr)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= INIT;
      player_x   <= X_W'(START_X);
      player_y   <= Y_W'(START_Y);
      draw_req   <= 1'b0;
      draw_erase <= 1'b0;
      draw_x     <= '0;
      draw_y     <= '0;
      wall_addr  <= '0;
      at_goal    <= 1'b0;
    end else begin
      case (state)
        // Reset leaves draw_req low; raise the initial player draw one
        // cycle later so an ack held over from before reset is ignored.
        INIT: begin
          if (!draw_req) begin
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
            draw_x     <= X_W'(START_X);
            draw_y     <= Y_W'(START_Y);
          end else if (draw_ack) begin
            draw_req <= 1'b0;
            state    <= IDLE;
          end
        end

        IDLE: begin
          if (tick && !at_goal && calc_ok) begin
            tgt_x     <= calc_x;
            tgt_y     <= calc_y;
            wall_addr <= calc_addr;
            wait_cnt  <= CNT_W'(MEM_LAT - 1);
            state     <= READ;
          end
        end

        READ: begin
          if (wait_cnt == '0) state <= CHECK;
          else                wait_cnt <= wait_cnt - 1'b1;
        end

        CHECK: begin
          if (wall_data) begin
            state <= IDLE;
          end else begin
            draw_req   <= 1'b1;
            draw_erase <= 1'b1;
            draw_x     <= player_x;
            draw_y     <= player_y;
            state      <= ERASE;
          end
        end

        // draw_req stays high across the ERASE->DRAW hand-over.
        ERASE: begin
          if (draw_ack) begin
            player_x   <= tgt_x;
            player_y   <= tgt_y;
            draw_x     <= tgt_x;
            draw_y     <= tgt_y;
            draw_erase <= 1'b0;
            state      <= DRAW;
          end
        end

        DRAW: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            if (tgt_x == X_W'(GOAL_X) && tgt_y == Y_W'(GOAL_Y)) at_goal <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_fsm.sv
module tb_player_move_fsm;

  localparam int GRID_W  = 20;
  localparam int GRID_H  = 15;
  localparam int GOAL_X  = 19;
  localparam int GOAL_Y  = 14;
  localparam int MEM_LAT = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [22:0] rate_count = 23'd1;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [8:0]  wall_addr;
  logic        wall_data;
  logic        draw_req;
  logic [4:0]  draw_x;
  logic [3:0]  draw_y;
  logic        draw_erase;
  logic        draw_ack = 1'b0;
  logic [4:0]  player_x;
  logic [3:0]  player_y;
  logic        at_goal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  int px = 0, py = 0, addr_m = 0;
  bit goal_m = 0;
  bit wall_map [0:511];
  logic [MEM_LAT-1:0] mem_pipe = '0;

  player_move_fsm #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(0), .START_Y(0),
    .GOAL_X(GOAL_X), .GOAL_Y(GOAL_Y), .MEM_LAT(MEM_LAT)
  ) dut (
    .clock(clock), .resetn(resetn), .rate_count(rate_count),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .wall_addr(wall_addr), .wall_data(wall_data),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_erase(draw_erase),
    .draw_ack(draw_ack), .player_x(player_x), .player_y(player_y),
    .at_goal(at_goal), .busy(busy)
  );

  always #5 clock = ~clock;

  // Wall memory: data for an address appears MEM_LAT cycles after it is presented.
  always @(posedge clock) mem_pipe <= {mem_pipe[MEM_LAT-2:0], wall_map[wall_addr]};
  assign wall_data = mem_pipe[MEM_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rate_count = 23'd1;
    {key_up, key_down, key_left, key_right} = 4'b0000;
  endtask

  task automatic noise();
    rate_count = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom_range(1, 5000000));
    {key_up, key_down, key_left, key_right} = 4'($urandom_range(0, 15));
  endtask

  task automatic model_reset();
    px = 0; py = 0; addr_m = 0; goal_m = 0;
  endtask

  task automatic init_seq();
    int n;
    n = 0;
    while (!draw_req && n < 5) begin cyc(); n++; end
    check("init_req", draw_req, 1);
    check("init_fields", {draw_erase, draw_x, draw_y}, {1'b0, 5'd0, 4'd0});
    check("init_busy", busy, 1);
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    check("init_done_req", draw_req, 0);
    check("init_done_busy", busy, 0);
    check("init_player", {player_x, player_y}, {5'd0, 4'd0});
  endtask

  // k = {up, down, left, right}
  task automatic try_move(input logic [3:0] k, input int ack_delay);
    int tx, ty, n;
    bit go;
    tx = px; ty = py; go = 0;
    if (!goal_m && k != 4'b0000) begin
      if (k[3])      begin if (py > 0)          begin go = 1; ty = py - 1; end end
      else if (k[2]) begin if (py < GRID_H - 1) begin go = 1; ty = py + 1; end end
      else if (k[1]) begin if (px > 0)          begin go = 1; tx = px - 1; end end
      else           begin if (px < GRID_W - 1) begin go = 1; tx = px + 1; end end
    end
    {key_up, key_down, key_left, key_right} = k;
    rate_count = 23'd0;
    cyc();
    quiet();
    if (!go) begin
      check("noop_busy", busy, 0);
      check("noop_addr", wall_addr, addr_m);
      check("noop_player", {player_x, player_y}, {5'(px), 4'(py)});
      return;
    end
    addr_m = ty * GRID_W + tx;
    check("addr", wall_addr, addr_m);
    check("busy", busy, 1);
    n = 0;
    while (busy && !draw_req && n < 20) begin
      noise();
      cyc();
      n++;
    end
    quiet();
    check("latency", n, MEM_LAT + 1);
    if (wall_map[addr_m]) begin
      check("blocked", {draw_req, busy}, 2'b00);
      check("blocked_player", {player_x, player_y}, {5'(px), 4'(py)});
      return;
    end
    check("erase_req", {draw_req, draw_erase, draw_x, draw_y}, {1'b1, 1'b1, 5'(px), 4'(py)});
    for (int i = 0; i < ack_delay; i++) begin
      noise();
      cyc();
      check("erase_hold", {draw_req, draw_erase, draw_x, draw_y}, {1'b1, 1'b1, 5'(px), 4'(py)});
    end
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    px = tx; py = ty;
    check("draw_req", {draw_req, draw_erase, draw_x, draw_y}, {1'b1, 1'b0, 5'(px), 4'(py)});
    check("player", {player_x, player_y}, {5'(px), 4'(py)});
    noise();
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    quiet();
    if (px == GOAL_X && py == GOAL_Y) goal_m = 1;
    check("done", {draw_req, busy}, 2'b00);
    check("at_goal", at_goal, goal_m);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) wall_map[i] = 0;
    model_reset();

    // reset state
    resetn = 1'b0;
    draw_ack = 1'b1;
    cyc(); cyc();
    draw_ack = 1'b0;
    check("rst_outputs", {draw_req, draw_erase, draw_x, draw_y, wall_addr, at_goal},
          {1'b0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0});
    check("rst_player", {player_x, player_y}, {5'd0, 4'd0});
    resetn = 1'b1;
    init_seq();

    // blocked down, off-grid up, open right, back left
    wall_map[20] = 1;
    try_move(4'b0100, 0);
    try_move(4'b1000, 0);
    try_move(4'b0001, 0);
    try_move(4'b0010, 0);
    wall_map[20] = 0;

    // walk to (5,5), then up+left together
    for (int i = 0; i < 5; i++) try_move(4'b0001, 0);
    for (int i = 0; i < 5; i++) try_move(4'b0100, 0);
    try_move(4'b1010, 0);
    check("prio_addr", wall_addr, 85);

    // ack withheld for 10 cycles with stray ticks
    try_move(4'b0001, 10);
    check("one_move", {player_x, player_y}, {5'd6, 4'd4});

    // reset in the middle of DRAW
    {key_up, key_down, key_left, key_right} = 4'b0001;
    rate_count = 23'd0;
    cyc();
    quiet();
    for (int i = 0; i < MEM_LAT + 1; i++) cyc();
    check("pre_rst_erase", {draw_req, draw_erase}, 2'b11);
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    check("pre_rst_draw", {draw_req, draw_erase, player_x}, {1'b1, 1'b0, 5'd7});
    resetn = 1'b0;
    cyc();
    check("mid_rst", {draw_req, player_x, player_y, at_goal, wall_addr}, {1'b0, 5'd0, 4'd0, 1'b0, 9'd0});
    resetn = 1'b1;
    model_reset();
    init_seq();

    // randomized walk over a random maze
    for (int i = 0; i < GRID_W * GRID_H; i++) wall_map[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 80; i++) try_move(4'($urandom_range(0, 15)), $urandom_range(0, 3));

    // clean reset, open maze, walk to the goal
    for (int i = 0; i < 512; i++) wall_map[i] = 0;
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    model_reset();
    init_seq();
    for (int i = 0; i < 18; i++) try_move(4'b0001, $urandom_range(0, 2));
    for (int i = 0; i < 14; i++) try_move(4'b0100, $urandom_range(0, 2));
    try_move(4'b0100, 0);
    check("pre_goal", at_goal, 0);
    try_move(4'b0001, 1);
    check("goal", {at_goal, player_x, player_y}, {1'b1, 5'd19, 4'd14});
    for (int i = 0; i < 4; i++) try_move(4'($urandom_range(1, 15)), 0);
    check("goal_sticky", at_goal, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_move_fsm.md
Name: player_move_fsm

Overview:
- Consumes the 8 Hz rate-divider count and issues one player step per tick.
- On each tick, samples the direction keys and computes the target cell.
- Checks the target cell against the maze wall memory, which has a fixed read latency.
- If the cell is open, commits the move and asks the VGA plot stage to erase the old cell and then draw the new one.
- Sits between the rate divider / key synchroniser upstream and the VGA plotter downstream.

Parameters:
- GRID_W, 20, maze width in cells
- GRID_H, 15, maze height in cells
- START_X, 0, player column after reset
- START_Y, 0, player row after reset
- GOAL_X, 19, goal column
- GOAL_Y, 14, goal row
- MEM_LAT, 2, wall-memory read latency in cycles (≥1)

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- rate_count  in  23  rate-divider count; tick = (rate_count == 0)
- key_up, key_down, key_left, key_right  in  1 each  synchronised direction keys, active high
- wall_addr  out  9  cell address = y*GRID_W + x
- wall_data  in  1  1 = wall; valid MEM_LAT cycles after wall_addr changes
- draw_req  out  1  plot request
- draw_x  out  5  plot column
- draw_y  out  4  plot row
- draw_erase  out  1  1 = erase cell, 0 = draw player
- draw_ack  in  1  plotter accepted the request
- player_x  out  5  current column
- player_y  out  4  current row
- at_goal  out  1  sticky: player has reached the goal
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (resetn low at a clock edge) forces, on that edge:
  - player_x=START_X, player_y=START_Y
  - draw_req=0, draw_erase=0, draw_x=0, draw_y=0, wall_addr=0
  - at_goal=0, state=INIT
- Reset takes priority over everything and aborts any operation in flight.
- States:
  - INIT: draw_req=1, draw_erase=0, draw_x/y=START. On draw_ack → IDLE.
  - IDLE: busy=0. On a cycle with tick, at_goal=0 and ≥1 key set:
    - Key priority: up > down > left > right. up=y-1, down=y+1, left=x-1, right=x+1.
    - If the target is off-grid (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down), stay in IDLE. No memory access.
    - Otherwise latch the target, register wall_addr and go to READ.
    - A tick with no key, or any tick while at_goal=1, is ignored.
  - READ: wait counter loaded with MEM_LAT-1 and counted down to 0, then → CHECK.
  - CHECK: samples wall_data exactly MEM_LAT cycles after wall_addr was registered.
    - wall_data=1 → IDLE, position unchanged.
    - wall_data=0 → ERASE.
  - ERASE: draw_req=1, draw_erase=1, draw_x/y = old position. On draw_ack:
    - player_x/y ← target
    - → DRAW
  - DRAW: draw_req=1, draw_erase=0, draw_x/y = new position. On draw_ack:
    - set at_goal if the new position = (GOAL_X, GOAL_Y)
    - → IDLE
- Handshake:
  - draw_req and draw_x/y/erase are registered and held stable until draw_ack is sampled high.
  - draw_req drops on the edge that samples draw_ack, except ERASE→DRAW, where it stays high and the fields change.
  - draw_ack while draw_req=0 is ignored.
- Ticks arriving while busy are dropped, not queued.
- Keys are sampled only in the tick cycle.
- Latency, open cell, ack returned the cycle after req: tick → first draw_req = MEM_LAT + 2 cycles.
- Arithmetic: unsigned. Bounds are checked before the ±1, so no wrap-around is possible.
- wall_addr is computed as a 9-bit y*GRID_W + x. Maximum is 299 at the defaults.

Decomposition:
- Shared package maze_pkg holds:
  - GRID_W, GRID_H, coordinate widths
  - state encoding constants (INIT, IDLE, READ, CHECK, ERASE, DRAW)
  - direction codes
- One sub-module, move_target_calc: combinational key-priority, bounds check and target/address generation. The FSM stays in the top module.

Test Plan:
- Reset released, ack returned 1 cycle after req → one draw at (0,0), erase=0; then busy=0, player=(0,0).
- Tick with key_right, wall_data=0 at addr 1:
  - erase request at (0,0), then draw at (1,0)
  - player_x=1
  - first draw_req exactly 4 cycles after the tick (MEM_LAT=2)
- Tick with key_down, wall_data=1 at addr 20 → no draw_req, player stays (0,0), busy for 3 cycles. Tick with key_up at (0,0) → no wall_addr change, busy stays 0.
- Simultaneous key_up and key_left at (5,5) → target (5,4), wall_addr=85.
- Ticks during an outstanding ERASE with ack withheld 10 cycles → draw_req and fields stable all 10 cycles, extra ticks dropped, exactly one move.
- Player at (18,14), key_right, open cell → at_goal=1 after the DRAW ack; further ticks with keys produce no activity.
- resetn low during DRAW → next edge: draw_req=0, player=(0,0); INIT draw follows release.
